servo_ramp_sequencer: RTL



---
 rtl/servo_ramp_sequencer.sv | 250 +++++++++++++++++++++++++
 1 files changed

// File: rtl/servo_ramp_sequencer.sv
// ---------------------------------------------------------------------------------------------
// servo_ramp_sequencer
//
// Programming-side sequencer for a 4-channel servo PWM controller. It keeps a target duty per
// channel and, once per update tick, moves each channel's current duty at most STEP counts toward
// its target. Each changed duty is written to the PWM controller through its
// channelselect/duty/latchbtn interface: the select and duty are set up, latchbtn is pulsed low,
// then released.
//
// Optional build macro: SERVO_SEQ_PRELOAD_EN
//   defined   - targets and currents reset to INIT_DUTY. The first cycle after reset release
//               starts a forced sweep that writes INIT_DUTY to all four channels, regardless of
//               enable and of the equality check.
//   undefined - targets and currents reset to 0. No write happens until a target differs.
//
// Ports:
//   clock         system clock
//   resetn        asynchronous active-low reset
//   enable        1 = update ticks start sweeps, 0 = ticks are dropped
//   cmd_valid     target write request
//   cmd_ready     target write accepted when cmd_valid & cmd_ready (high only in idle)
//   cmd_channel   channel to retarget
//   cmd_target    new target duty
//   channelselect channel select to the PWM controller
//   duty          duty value to the PWM controller
//   latchbtn      latch strobe to the PWM controller, active low, idles high
//   busy          high whenever a sweep is in progress
//   at_target     bit i set when channel i current duty equals its target
// ---------------------------------------------------------------------------------------------

module servo_ramp_sequencer #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned UPDATE_HZ = 50,
  parameter int unsigned STEP      = 4,
  parameter int unsigned SETUP_CYC = 2,
  parameter int unsigned PULSE_CYC = 2,
  parameter logic [7:0]  INIT_DUTY = 8'h80
) (
  input  logic       clock,
  input  logic       resetn,
  input  logic       enable,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_channel,
  input  logic [7:0] cmd_target,
  output logic [1:0] channelselect,
  output logic [7:0] duty,
  output logic       latchbtn,
  output logic       busy,
  output logic [3:0] at_target
);

  // -------------------------------------------------------------------------------------------
  // Derived constants
  // -------------------------------------------------------------------------------------------
  localparam int unsigned TickDiv = (CLK_HZ / UPDATE_HZ > 0) ? (CLK_HZ / UPDATE_HZ) : 1;
  localparam int unsigned TickW   = (TickDiv > 1) ? $clog2(TickDiv) : 1;
  localparam logic [TickW-1:0] TickLast = TickW'(TickDiv - 1);

  localparam int unsigned CycMax = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
  localparam int unsigned CycW   = (CycMax > 1) ? $clog2(CycMax) : 1;
  localparam logic [CycW-1:0] SetupLast = CycW'(SETUP_CYC - 1);
  localparam logic [CycW-1:0] PulseLast = CycW'(PULSE_CYC - 1);

  localparam logic [8:0] StepWide = 9'(STEP);
  localparam logic [7:0] StepByte = 8'(STEP);

`ifdef SERVO_SEQ_PRELOAD_EN
  localparam logic [7:0] RstDuty  = INIT_DUTY;
  localparam logic       RstForce = 1'b1;
`else
  localparam logic [7:0] RstDuty  = 8'h00;
  localparam logic       RstForce = 1'b0;
`endif

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StScan  = 3'd1,
    StSetup = 3'd2,
    StPulse = 3'd3,
    StHold  = 3'd4
  } state_e;

  // -------------------------------------------------------------------------------------------
  // State
  // -------------------------------------------------------------------------------------------
  state_e          state_q;
  logic [1:0]      ch_q;
  logic [CycW-1:0] cyc_q;
  logic            latch_q;
  logic [1:0]      chsel_q;
  logic [7:0]      duty_q;
  logic            tick_pending_q;
  logic            force_q;
  logic [7:0]      target_q  [4];
  logic [7:0]      current_q [4];

  logic [TickW-1:0] tick_cnt_q, tick_cnt_d;
  logic             tick;

  // -------------------------------------------------------------------------------------------
  // Update tick: free-running divider, independent of enable
  // -------------------------------------------------------------------------------------------
  always_comb begin
    tick       = (tick_cnt_q == TickLast);
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      tick_cnt_q <= '0;
    end else begin
      tick_cnt_q <= tick_cnt_d;
    end
  end

  // -------------------------------------------------------------------------------------------
  // Slew arithmetic for the channel under scan. The difference is taken in 9 bits on the
  // ordered operands so the step can never overshoot the target or wrap past 0/255.
  // -------------------------------------------------------------------------------------------
  logic [7:0] cur_sel;
  logic [7:0] tgt_sel;
  logic [8:0] diff;
  logic [7:0] slew_duty_d;
  logic       need_write;

  always_comb begin
    cur_sel     = current_q[ch_q];
    tgt_sel     = target_q[ch_q];
    diff        = '0;
    slew_duty_d = cur_sel;
    if (tgt_sel > cur_sel) begin
      diff        = {1'b0, tgt_sel} - {1'b0, cur_sel};
      slew_duty_d = (diff <= StepWide) ? tgt_sel : cur_sel + StepByte;
    end else if (tgt_sel < cur_sel) begin
      diff        = {1'b0, cur_sel} - {1'b0, tgt_sel};
      slew_duty_d = (diff <= StepWide) ? tgt_sel : cur_sel - StepByte;
    end
    // The forced preload sweep writes even channels that already match.
    need_write = (cur_sel != tgt_sel) || force_q;
  end

  // -------------------------------------------------------------------------------------------
  // Sequencer FSM with registered outputs
  // -------------------------------------------------------------------------------------------
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q        <= StIdle;
      ch_q           <= 2'd0;
      cyc_q          <= '0;
      latch_q        <= 1'b1;
      chsel_q        <= 2'd0;
      duty_q         <= 8'h00;
      tick_pending_q <= 1'b0;
      force_q        <= RstForce;
      for (int i = 0; i < 4; i++) begin
        target_q[i]  <= RstDuty;
        current_q[i] <= RstDuty;
      end
    end else begin
      // cmd_ready is only high in idle, so a target never changes under an active scan.
      if (cmd_valid && cmd_ready) begin
        target_q[cmd_channel] <= cmd_target;
      end

      unique case (state_q)
        StIdle: begin
          if (tick_pending_q || force_q) begin
            state_q        <= StScan;
            ch_q           <= 2'd0;
            tick_pending_q <= 1'b0;
          end
        end

        StScan: begin
          if (need_write) begin
            current_q[ch_q] <= slew_duty_d;
            chsel_q         <= ch_q;
            duty_q          <= slew_duty_d;
            cyc_q           <= '0;
            state_q         <= StSetup;
          end else if (ch_q == 2'd3) begin
            state_q <= StIdle;
            force_q <= 1'b0;
          end else begin
            ch_q <= ch_q + 2'd1;
          end
        end

        StSetup: begin
          if (cyc_q == SetupLast) begin
            cyc_q   <= '0;
            latch_q <= 1'b0;
            state_q <= StPulse;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end

        StPulse: begin
          if (cyc_q == PulseLast) begin
            cyc_q   <= '0;
            latch_q <= 1'b1;
            state_q <= StHold;
          end else begin
            cyc_q <= cyc_q + 1'b1;
          end
        end

        StHold: begin
          if (ch_q == 2'd3) begin
            state_q <= StIdle;
            force_q <= 1'b0;
          end else begin
            ch_q    <= ch_q + 2'd1;
            state_q <= StScan;
          end
        end

        default: begin
          state_q <= StIdle;
          latch_q <= 1'b1;
        end
      endcase

      // Placed after the FSM so a tick arriving as the sweep launches is still remembered;
      // ticks during a sweep collapse into this single flag.
      if (tick && enable) begin
        tick_pending_q <= 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------------------------
  always_comb begin
    at_target = 4'h0;
    for (int i = 0; i < 4; i++) begin
      at_target[i] = (current_q[i] == target_q[i]);
    end
  end

  assign cmd_ready     = (state_q == StIdle);
  assign busy          = (state_q != StIdle);
  assign channelselect = chsel_q;
  assign duty          = duty_q;
  assign latchbtn      = latch_q;

endmodule
